// File: rtl/conv_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_sched_pkg
//
// Shared types for the 3x3 convolution window scheduler.
//   SCHED_DIM_W   : default width of geometry fields and position counters
//   sched_state_t : frame sequencer states
//   pos_tag_t     : position tag carried alongside each window beat
// ---------------------------------------------------------------------------
package conv_sched_pkg;

    localparam int SCHED_DIM_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Tag fields are sized by SCHED_DIM_W, so the scheduler's DIM_W parameter
    // must stay equal to it.
    typedef struct packed {
        logic                   legal;
        logic [SCHED_DIM_W-1:0] row;
        logic [SCHED_DIM_W-1:0] col;
    } pos_tag_t;

endpackage

// File: rtl/conv_window_scheduler_tag_pipe.sv
// ---------------------------------------------------------------------------
// sched_tag_pipe
//
// Enabled shift register of position tags. A tag is shifted in only when
// shift_en is high, so the pipe advances in lock-step with the window beats
// rather than with the clock.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear of all stages (start of a new frame)
//   shift_en  : advance the pipe by one stage
//   tag_in    : tag entering stage 0
//   tag_head  : oldest tag (last stage)
// ---------------------------------------------------------------------------
module sched_tag_pipe
    import conv_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     shift_en,
    input  pos_tag_t tag_in,
    output pos_tag_t tag_head
);

    pos_tag_t stage_q [DEPTH];
    pos_tag_t stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (shift_en) begin
            stage_d[0] = tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_head = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler
//
// Frame-level sequencer for the 3x3 line-buffered kernel window. One frame is
// accepted per start command: the window is cleared, the stream is forwarded
// beat by beat under downstream backpressure, every window beat is tagged
// with its centre position, windows straddling a row boundary are masked,
// and the window pipeline is flushed with WIN_LAT zero beats at frame end.
//
// Optional feature macro: SCHED_PERF_EN adds perf_stall_cycles and
// perf_windows saturating 32-bit counters (cleared at every frame start).
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : frame start request (sampled in IDLE only)
//   cfg_width/height/channels: frame geometry, latched at start
//   in_pixel/in_valid/in_ready : upstream stream handshake
//   out_ready                : consumer can take a window this cycle
//   win_clear                : one-cycle clear to the kernel window
//   win_pixel/win_data_valid : beat into the kernel window
//   win_valid_in             : kernel window valid_out
//   out_valid/row/col/last   : legal window flag, centre position, last flag
//   busy, done, cfg_err      : status
//   perf_stall_cycles, perf_windows : only with SCHED_PERF_EN
// ---------------------------------------------------------------------------
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DIM_W         = SCHED_DIM_W,
    parameter int PIX_W         = 64,
    parameter int WIN_LAT       = 2,
    parameter int MAX_ROW_BEATS = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [DIM_W-1:0] cfg_channels,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             win_clear,
    output logic [PIX_W-1:0] win_pixel,
    output logic             win_data_valid,
    input  logic             win_valid_in,
    output logic             out_valid,
    output logic [DIM_W-1:0] out_row,
    output logic [DIM_W-1:0] out_col,
    output logic             out_last,
    output logic             busy,
    output logic             done,
`ifdef SCHED_PERF_EN
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_windows,
`endif
    output logic             cfg_err
);

    localparam int                 FL_W   = (WIN_LAT < 2) ? 1 : $clog2(WIN_LAT);
    localparam logic [2*DIM_W-1:0] MAX_RB = (2*DIM_W)'(MAX_ROW_BEATS);

    sched_state_t     state_q, state_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] row_beats_q, row_beats_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic             win_data_valid_q, win_data_valid_d;
    logic [PIX_W-1:0] win_pixel_q, win_pixel_d;
    logic             win_dv_d1_q, win_dv_d1_d;
    pos_tag_t         tag_q, tag_d;
    pos_tag_t         tag_d1_q, tag_d1_d;
    logic             cfg_err_q, cfg_err_d;

    logic [2*DIM_W-1:0] row_beats_full;
    logic               cfg_bad;
    logic               accept;
    logic               last_beat;
    pos_tag_t           head;

    // Geometry check uses the full-width product so an overflowing
    // width*channels cannot alias into an acceptable row length.
    assign row_beats_full = {{DIM_W{1'b0}}, cfg_width} * {{DIM_W{1'b0}}, cfg_channels};
    assign cfg_bad = (cfg_width < DIM_W'(3)) || (cfg_height < DIM_W'(3)) ||
                     (cfg_channels == '0) || (row_beats_full > MAX_RB);

    assign in_ready  = (state_q == RUN) && out_ready;
    assign accept    = in_ready && in_valid;
    assign last_beat = (row_q == height_q - DIM_W'(1)) && (col_q == row_beats_q - DIM_W'(1));

    always_comb begin
        state_d          = state_q;
        height_d         = height_q;
        row_beats_d      = row_beats_q;
        row_d            = row_q;
        col_d            = col_q;
        flush_d          = flush_q;
        win_data_valid_d = 1'b0;
        win_pixel_d      = win_pixel_q;
        tag_d            = tag_q;
        cfg_err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        height_d    = cfg_height;
                        row_beats_d = row_beats_full[DIM_W-1:0];
                        state_d     = CLEAR;
                    end
                end
            end
            CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                flush_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    win_data_valid_d = 1'b1;
                    win_pixel_d      = in_pixel;
                    // A window is only complete once two full rows and two
                    // columns precede the incoming pixel; its centre then
                    // sits one row up and one column left.
                    tag_d.legal = (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
                    tag_d.row   = row_q - DIM_W'(1);
                    tag_d.col   = col_q - DIM_W'(1);
                    if (col_q == row_beats_q - DIM_W'(1)) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Zero beats push the final real windows out of the kernel
                // window; their own tags are never legal.
                if (out_ready) begin
                    win_data_valid_d = 1'b1;
                    win_pixel_d      = '0;
                    tag_d            = '0;
                    if (flush_q == FL_W'(WIN_LAT - 1)) begin
                        state_d = DONE;
                    end else begin
                        flush_d = flush_q + FL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The tag of a beat is held until the cycle its data_valid has been seen
    // by the window, then shifted into the pipe; the head is therefore the
    // tag of the beat WIN_LAT beats older than the one just delivered.
    always_comb begin
        win_dv_d1_d = win_data_valid_q;
        tag_d1_d    = win_data_valid_q ? tag_q : tag_d1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            height_q         <= '0;
            row_beats_q      <= '0;
            row_q            <= '0;
            col_q            <= '0;
            flush_q          <= '0;
            win_data_valid_q <= 1'b0;
            win_pixel_q      <= '0;
            win_dv_d1_q      <= 1'b0;
            tag_q            <= '0;
            tag_d1_q         <= '0;
            cfg_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            height_q         <= height_d;
            row_beats_q      <= row_beats_d;
            row_q            <= row_d;
            col_q            <= col_d;
            flush_q          <= flush_d;
            win_data_valid_q <= win_data_valid_d;
            win_pixel_q      <= win_pixel_d;
            win_dv_d1_q      <= win_dv_d1_d;
            tag_q            <= tag_d;
            tag_d1_q         <= tag_d1_d;
            cfg_err_q        <= cfg_err_d;
        end
    end

    sched_tag_pipe #(
        .DEPTH (WIN_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == CLEAR),
        .shift_en (win_dv_d1_q),
        .tag_in   (tag_d1_q),
        .tag_head (head)
    );

    assign win_clear      = (state_q == CLEAR);
    assign win_pixel      = win_pixel_q;
    assign win_data_valid = win_data_valid_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign cfg_err        = cfg_err_q;

    assign out_valid = win_dv_d1_q && win_valid_in && head.legal;
    assign out_row   = head.row;
    assign out_col   = head.col;
    assign out_last  = out_valid && (head.row == height_q - DIM_W'(2)) &&
                       (head.col == row_beats_q - DIM_W'(2));

`ifdef SCHED_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_win_q, perf_win_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_win_d   = perf_win_q;
        if (state_q == CLEAR) begin
            perf_stall_d = '0;
            perf_win_d   = '0;
        end else begin
            if ((state_q == RUN) && in_valid && !out_ready && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
            if (out_valid && (perf_win_q != '1)) begin
                perf_win_d = perf_win_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_win_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_win_q   <= perf_win_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_windows      = perf_win_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_window_scheduler
//
// Self-checking bench for conv_window_scheduler. Expected window positions
// and expected window-input pixels are queued when a frame is launched and
// consumed by a monitor as the scheduler produces them. The kernel window is
// modelled as a one-cycle delay of data_valid onto valid_out.
// ---------------------------------------------------------------------------
module tb_conv_window_scheduler;

    localparam int DIM_W   = 16;
    localparam int PIX_W   = 64;
    localparam int WIN_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DIM_W-1:0] cfg_width, cfg_height, cfg_channels;
    logic [PIX_W-1:0] in_pixel;
    logic             in_valid, in_ready, out_ready;
    logic             win_clear;
    logic [PIX_W-1:0] win_pixel;
    logic             win_data_valid;
    logic             win_valid_in;
    logic             out_valid;
    logic [DIM_W-1:0] out_row, out_col;
    logic             out_last, busy, done, cfg_err;
`ifdef SCHED_PERF_EN
    logic [31:0]      perf_stall_cycles, perf_windows;
`endif

    typedef struct {
        int row;
        int col;
        bit last;
    } win_exp_t;

    win_exp_t         win_q[$];
    logic [PIX_W-1:0] pix_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int clear_cnt = 0;
    int err_cnt = 0;
    int win_seen = 0;

    conv_window_scheduler #(
        .DIM_W         (DIM_W),
        .PIX_W         (PIX_W),
        .WIN_LAT       (WIN_LAT),
        .MAX_ROW_BEATS (8192)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_channels   (cfg_channels),
        .in_pixel       (in_pixel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .win_clear      (win_clear),
        .win_pixel      (win_pixel),
        .win_data_valid (win_data_valid),
        .win_valid_in   (win_valid_in),
        .out_valid      (out_valid),
        .out_row        (out_row),
        .out_col        (out_col),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
`ifdef SCHED_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_windows      (perf_windows),
`endif
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    // Kernel window model: valid_out follows data_valid by one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) win_valid_in <= 1'b0;
        else     win_valid_in <= win_data_valid;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pixOf(input int f, input int i);
        return {32'hC0DE0000 + 32'(f), 32'(i) ^ 32'h5A5A0000};
    endfunction

    always @(negedge clk) begin : monitor
        win_exp_t         w;
        logic [PIX_W-1:0] p;
        if (rst !== 1'b1) begin
            if (done === 1'b1)      done_cnt++;
            if (win_clear === 1'b1) clear_cnt++;
            if (cfg_err === 1'b1)   err_cnt++;
            if (out_ready === 1'b0) checkOutput("in_ready_blocked", 64'(in_ready), 64'd0);
            if (win_data_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    checkOutput("pix_extra", 64'(win_data_valid), 64'd0);
                end else begin
                    p = pix_q.pop_front();
                    checkOutput("win_pixel", win_pixel, p);
                end
            end
            if (out_valid === 1'b1) begin
                win_seen++;
                if (win_q.size() == 0) begin
                    checkOutput("win_extra", 64'(out_valid), 64'd0);
                end else begin
                    w = win_q.pop_front();
                    checkOutput("win_row", 64'(out_row), 64'(w.row));
                    checkOutput("win_col", 64'(out_col), 64'(w.col));
                    checkOutput("win_last", 64'(out_last), 64'(w.last));
                end
            end
        end
    end

    task automatic checkResetOutputs(input string p);
        checkOutput({p, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({p, "_win_clear"}, 64'(win_clear), 64'd0);
        checkOutput({p, "_win_pixel"}, win_pixel, 64'd0);
        checkOutput({p, "_win_dv"}, 64'(win_data_valid), 64'd0);
        checkOutput({p, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({p, "_out_row"}, 64'(out_row), 64'd0);
        checkOutput({p, "_out_col"}, 64'(out_col), 64'd0);
        checkOutput({p, "_out_last"}, 64'(out_last), 64'd0);
        checkOutput({p, "_busy"}, 64'(busy), 64'd0);
        checkOutput({p, "_done"}, 64'(done), 64'd0);
        checkOutput({p, "_cfg_err"}, 64'(cfg_err), 64'd0);
    endtask

    // Launches one frame; abort_at>0 resets the DUT after that many beats,
    // restart_at>0 raises start again once that many beats have gone in.
    task automatic applyStimulus(input int w, input int h, input int ch, input bit toggle,
                                 input int abort_at, input int restart_at, input int fid);
        int rb;
        int total;
        int idx;
        int cyc;
        int exp_win;
        bit acc;
        rb      = w * ch;
        total   = rb * h;
        idx     = 0;
        cyc     = 0;
        exp_win = 0;
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= rb - 2; c++) begin
                win_q.push_back('{r, c, (r == h - 2) && (c == rb - 2)});
                exp_win++;
            end
        end
        for (int i = 0; i < total; i++) pix_q.push_back(pixOf(fid, i));
        for (int i = 0; i < WIN_LAT; i++) pix_q.push_back('0);
        done_cnt = 0; clear_cnt = 0; err_cnt = 0; win_seen = 0;
        $display("[TB] frame %0d: %0dx%0d ch=%0d toggle=%0d", fid, w, h, ch, toggle);

        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_channels = DIM_W'(ch);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (idx < total && cyc < 1000) begin
            in_valid  = 1'b1;
            in_pixel  = pixOf(fid, idx);
            out_ready = toggle ? ~out_ready : 1'b1;
            start     = (restart_at > 0) && (idx == restart_at);
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_at > 0 && idx == abort_at) break;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;

        if (abort_at > 0) begin
            rst = 1'b1;
            #1;
            checkResetOutputs("abort");
            checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
            win_q.delete();
            pix_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            return;
        end

        checkOutput("beats_accepted", 64'(idx), 64'(total));
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("frame_end_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("clear_pulses", 64'(clear_cnt), 64'd1);
        checkOutput("cfg_err_pulses", 64'(err_cnt), 64'd0);
        checkOutput("windows_seen", 64'(win_seen), 64'(exp_win));
        checkOutput("win_q_left", 64'(win_q.size()), 64'd0);
        checkOutput("pix_q_left", 64'(pix_q.size()), 64'd0);
    endtask

    task automatic checkBadConfig(input int w, input int h, input int ch, input string tag);
        $display("[TB] bad config %s", tag);
        err_cnt = 0; clear_cnt = 0;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_channels = DIM_W'(ch);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_cfg_err"}, 64'(cfg_err), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_cfg_err_pulse"}, 64'(cfg_err), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_no_clear"}, 64'(clear_cnt), 64'd0);
        checkOutput({tag, "_err_count"}, 64'(err_cnt), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_channels = '0;
        in_pixel = '0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        checkResetOutputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4, 4, 1, 1'b0, 0, 0, 1);
        applyStimulus(5, 3, 2, 1'b0, 0, 0, 2);
        applyStimulus(4, 4, 1, 1'b1, 0, 0, 3);

        checkBadConfig(2, 4, 1, "w2");
        checkBadConfig(4, 2, 1, "h2");
        checkBadConfig(4, 4, 0, "ch0");
        checkBadConfig(100, 4, 100, "rb_big");

        applyStimulus(4, 4, 1, 1'b0, 7, 0, 4);
        @(posedge clk); #1;
        applyStimulus(4, 4, 1, 1'b0, 0, 0, 5);
        applyStimulus(4, 4, 1, 1'b0, 0, 5, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
